rvfi_imem_responder: RTL
========================

# rvfi_imem_responder

Formal-harness instruction-memory responder: serves the core's instruction-fetch requests and returns 32-bit fetch data that is unconstrained everywhere except at the symbolic halfword location (imem_addr, imem_data). At that location it always returns imem_data, so the same symbolic pair can be fed to the RVFI instruction-memory checker. It sits between the core's fetch port and the solver-driven data inputs in the formal testbench, and buffers up to DEPTH outstanding fetches with a fixed response latency.

## Interface
- XLEN, 32, address width.
- LATENCY, 1, cycles from request acceptance to earliest response; legal range 1..8.
- DEPTH, 4, maximum outstanding (accepted, unconsumed) fetches; power of two, 2..16.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  in  XLEN  symbolic halfword address; bit 0 ignored.
- imem_data  in  16  symbolic halfword stored at imem_addr.
- fetch_valid  in  1  fetch request present.
- fetch_ready  out  1  responder can accept a request.
- fetch_addr  in  XLEN  fetch address; bit 0 ignored (halfword aligned).
- arb_data  in  32  solver-chosen data for the fetch accepted this cycle.
- rsp_valid  out  1  head response available.
- rsp_ready  in  1  core consumes head response.
- rsp_data  out  32  [15:0] = halfword at A, [31:16] = halfword at A+2.
- rsp_addr  out  XLEN  fetch_addr of head response, bit 0 cleared.
- stall  in  1  solver backpressure (present only with RVFI_IMEM_STALL_EN).

## Operation
- Accept when fetch_valid && fetch_ready. Let A = fetch_addr & ~1, M = imem_addr & ~1.
- Captured data D = arb_data, then: if A == M, D[15:0] = imem_data; if (A + 2) mod 2^XLEN == M, D[31:16] = imem_data. Both substitutions are evaluated independently; the +2 wraps modulo 2^XLEN (A = all-ones-minus-1 with M = 0 substitutes the upper half).
- Captured {A, D, timer = LATENCY} is pushed into a DEPTH-entry in-order FIFO.
- Each cycle, every entry's timer decrements, saturating at 0.
- rsp_valid = FIFO non-empty && head timer == 0; rsp_data/rsp_addr show the head entry.
- Pop on rsp_valid && rsp_ready. Responses leave strictly in acceptance order.
- fetch_ready = (count < DEPTH); it does not depend on rsp_ready (no same-cycle pop bypass when full).
- Simultaneous push and pop: count unchanged; both take effect.
- rsp_data/rsp_addr hold stable while rsp_valid && !rsp_ready.
- imem_addr/imem_data are sampled at acceptance only; the harness holds them constant, and the block does not re-check them.

## Timing
- Reset (asynchronous): FIFO empty, count 0, all timers 0, rsp_valid 0, rsp_data 0, rsp_addr 0. fetch_ready is 0 while reset is high and 1 in the first cycle after release.
- Request accepted at edge t: rsp_valid is high at earliest after edge t+LATENCY, if the entry is at the head.
- Back-to-back acceptance gives one response per cycle at steady state.
- Reset asserted mid-operation discards all outstanding entries immediately. No response is produced for them after release.

## Configuration
- RVFI_IMEM_STALL_EN defined: stall port exists, and fetch_ready = (count < DEPTH) && !stall. This lets the solver exercise arbitrary fetch backpressure.
- Not defined: stall port absent, and fetch_ready = (count < DEPTH).

## Test plan
- imem_addr=0x100, imem_data=0xBEEF, fetch 0x100 with arb_data=0x12345678, LATENCY=1 -> next cycle rsp_valid=1, rsp_data=0x1234BEEF, rsp_addr=0x100.
- Same symbolic pair, fetch 0x0FE with arb_data=0x12345678 -> rsp_data=0xBEEF5678; fetch 0x0FF -> identical (bit 0 ignored).
- imem_addr=0x0, fetch 0xFFFFFFFE with arb_data=0xAAAABBBB -> rsp_data=0xBEEFBBBB (wrap-around substitution).
- DEPTH=4, rsp_ready=0, five consecutive requests -> four accepted, fetch_ready=0 on the fifth. Then rsp_ready=1 -> responses return in order, and fetch_ready returns to 1 the cycle after the first pop.
- LATENCY=3, request at t -> rsp_valid rises after edge t+3. Reset pulsed at t+1 -> rsp_valid stays 0, and the FIFO is empty after release.
- RVFI_IMEM_STALL_EN defined with stall=1 and FIFO empty -> fetch_ready=0 and no acceptance. stall=0 -> fetch_ready=1 in the same cycle.

Source files
------------

// File: rtl/rvfi_imem_responder_if.sv
// Fetch request / response handshake between the core's instruction-fetch port and the imem responder.
interface rvfi_imem_responder_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic [XLEN-1:0] rsp_addr;

  modport master (
    output fetch_valid, fetch_addr, rsp_ready,
    input  fetch_ready, rsp_valid, rsp_data, rsp_addr
  );

  modport slave (
    input  fetch_valid, fetch_addr, rsp_ready,
    output fetch_ready, rsp_valid, rsp_data, rsp_addr
  );
endinterface

// File: rtl/rvfi_imem_responder.sv
// Formal-harness instruction memory: solver-chosen fetch data except at the symbolic halfword, fixed latency, in-order FIFO.
// Define RVFI_IMEM_STALL_EN to add a solver-driven stall input that withholds fetch_ready.
module rvfi_imem_responder #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic [31:0]     arb_data,
`ifdef RVFI_IMEM_STALL_EN
  input  logic            stall,
`endif
  rvfi_imem_responder_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = 4;
  localparam logic [XLEN-1:0] HALF_MASK = ~(XLEN'(1));
  localparam logic [TW-1:0]   LAT_INIT  = TW'(LATENCY);
  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);

  logic [XLEN-1:0] q_addr [DEPTH];
  logic [31:0]     q_data [DEPTH];
  logic [TW-1:0]   q_tmr  [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            stall_int;
  logic            accept;
  logic            pop;
  logic [XLEN-1:0] fetch_a;
  logic [XLEN-1:0] fetch_a2;
  logic [XLEN-1:0] sym_a;
  logic [31:0]     cap_data;

`ifdef RVFI_IMEM_STALL_EN
  assign stall_int = stall;
`else
  assign stall_int = 1'b0;
`endif

  // Ready is held low during reset so nothing is accepted while the FIFO is being cleared.
  assign bus.fetch_ready = !reset && (count < DEPTH_C) && !stall_int;
  assign bus.rsp_valid   = (count != '0) && (q_tmr[rd_ptr] == '0);
  assign bus.rsp_data    = q_data[rd_ptr];
  assign bus.rsp_addr    = q_addr[rd_ptr];

  assign accept = bus.fetch_valid && bus.fetch_ready;
  assign pop    = bus.rsp_valid && bus.rsp_ready;

  // Each half of the fetched word is substituted independently; A+2 wraps at the top of the address space.
  always_comb begin
    fetch_a  = bus.fetch_addr & HALF_MASK;
    sym_a    = imem_addr & HALF_MASK;
    fetch_a2 = fetch_a + XLEN'(2);
    cap_data = arb_data;
    if (fetch_a == sym_a) begin
      cap_data[15:0] = imem_data;
    end
    if (fetch_a2 == sym_a) begin
      cap_data[31:16] = imem_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
        q_tmr[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && (wr_ptr == PW'(i))) begin
          q_addr[i] <= fetch_a;
          q_data[i] <= cap_data;
          q_tmr[i]  <= LAT_INIT;
        end else if (q_tmr[i] != '0) begin
          q_tmr[i] <= q_tmr[i] - TW'(1);
        end
      end
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
